// File: rtl/method_rom_arbiter.sv
// Two-port read arbiter for a shared single-port image ROM. Port 0 has fixed priority,
// and port 1 is guaranteed a slot after STARVE_LIMIT consecutive denied cycles.
module method_rom_arbiter #(
   parameter int ADDR_W       = 13,
   parameter int DATA_W       = 16,
   parameter int DEPTH        = 8100,
   parameter int STARVE_LIMIT = 4,
   parameter int CNT_W        = 8
) (
   input  logic              clka,
   input  logic              rsta,
   input  logic              req0,
   input  logic [ADDR_W-1:0] addr0,
   output logic              gnt0,
   output logic              rvalid0,
   output logic [DATA_W-1:0] rdata0,
   output logic              rerr0,
   input  logic              req1,
   input  logic [ADDR_W-1:0] addr1,
   output logic              gnt1,
   output logic              rvalid1,
   output logic [DATA_W-1:0] rdata1,
   output logic              rerr1,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [DATA_W-1:0] rom_doa
);

   localparam logic [ADDR_W:0]  DEPTH_C = (ADDR_W+1)'(DEPTH);
   localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STARVE_LIMIT);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [CNT_W-1:0]  starve_cnt;
   logic [ADDR_W-1:0] last_addr;
   logic [ADDR_W-1:0] gaddr;
   logic              gerr;
   logic              issue;
   logic              force1;

   // Stage-1 tag for the read in flight; the ROM data arrives one cycle later.
   typedef struct packed {
      logic valid;
      logic port;
      logic err;
   } tag_t;

   tag_t s1;

   assign force1 = (STARVE_LIMIT != 0) && (starve_cnt >= LIMIT_C);

   always_comb begin
      // NOTE: every output of this block gets a default first so no latch is inferred.
      gnt0     = 1'b0;
      gnt1     = 1'b0;
      if (!rsta) begin
         if (req1 && (!req0 || force1))
            gnt1 = 1'b1;
         else if (req0)
            gnt0 = 1'b1;
      end
      issue    = gnt0 | gnt1;
      gaddr    = gnt1 ? addr1 : addr0;
      gerr     = {1'b0, gaddr} >= DEPTH_C;
      rom_addr = last_addr;
      if (rsta)
         rom_addr = '0;
      else if (issue)
         rom_addr = gerr ? '0 : gaddr;
   end

   always_ff @(posedge clka) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (rsta) begin
         starve_cnt <= '0;
         last_addr  <= '0;
         s1         <= '0;
         rvalid0    <= 1'b0;
         rvalid1    <= 1'b0;
         rdata0     <= '0;
         rdata1     <= '0;
         rerr0      <= 1'b0;
         rerr1      <= 1'b0;
      end else begin
         if (issue)
            last_addr <= rom_addr;

         if (req1 && !gnt1) begin
            if (starve_cnt != CNT_MAX)
               starve_cnt <= starve_cnt + 1'b1;
         end else begin
            starve_cnt <= '0;
         end

         s1.valid <= issue;
         s1.port  <= gnt1;
         s1.err   <= gerr;

         rvalid0 <= s1.valid && !s1.port;
         rvalid1 <= s1.valid &&  s1.port;
         // Out-of-range reads still occupy the ROM at address 0, so their data is dropped here.
         if (s1.valid) begin
            if (s1.port) begin
               rdata1 <= s1.err ? '0 : rom_doa;
               rerr1  <= s1.err;
            end else begin
               rdata0 <= s1.err ? '0 : rom_doa;
               rerr0  <= s1.err;
            end
         end
      end
   end

endmodule

// File: tb/tb_method_rom_arbiter.sv
// Directed bench for method_rom_arbiter: a cycle-level reference model checks every cycle,
// and hand-computed literals pin the model's own expectations.
module tb_method_rom_arbiter;

   localparam int DEPTH = 8100;

   logic        clka = 1'b0;
   logic        rsta = 1'b1;
   logic        req0 = 1'b0, req1 = 1'b0;
   logic [12:0] addr0 = '0, addr1 = '0;
   logic        gnt0, gnt1, rvalid0, rvalid1, rerr0, rerr1;
   logic [15:0] rdata0, rdata1, rom_doa;
   logic [12:0] rom_addr;

   logic        z_req0 = 1'b0, z_req1 = 1'b0;
   logic [12:0] z_addr0 = '0, z_addr1 = '0;
   logic        z_gnt0, z_gnt1, z_rvalid0, z_rvalid1, z_rerr0, z_rerr1;
   logic [15:0] z_rdata0, z_rdata1, z_rom_doa;
   logic [12:0] z_rom_addr;

   always #5 clka = ~clka;

   method_rom_arbiter #(.STARVE_LIMIT(4)) dut (
      .clka(clka), .rsta(rsta),
      .req0(req0), .addr0(addr0), .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0), .rerr0(rerr0),
      .req1(req1), .addr1(addr1), .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1), .rerr1(rerr1),
      .rom_addr(rom_addr), .rom_doa(rom_doa));

   method_rom_arbiter #(.STARVE_LIMIT(0)) dut_strict (
      .clka(clka), .rsta(rsta),
      .req0(z_req0), .addr0(z_addr0), .gnt0(z_gnt0), .rvalid0(z_rvalid0), .rdata0(z_rdata0), .rerr0(z_rerr0),
      .req1(z_req1), .addr1(z_addr1), .gnt1(z_gnt1), .rvalid1(z_rvalid1), .rdata1(z_rdata1), .rerr1(z_rerr1),
      .rom_addr(z_rom_addr), .rom_doa(z_rom_doa));

   function automatic logic [15:0] rom_fn(input logic [12:0] a);
      rom_fn = {a[7:0], 3'b000, a[12:8]} ^ 16'hC3A5;
   endfunction

   // ROM: one-cycle read latency.
   always @(posedge clka) begin
      rom_doa   <= rom_fn(rom_addr);
      z_rom_doa <= rom_fn(z_rom_addr);
   end

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clka);
      #1;
   endtask

   // Reference model: requests in flight, consecutive-denial count, last issued address, held data.
   typedef struct packed {
      logic        v;
      logic        port;
      logic [12:0] addr;
   } rd_t;

   rd_t         p1 = '0, p2 = '0;
   int          deny = 0;
   logic [12:0] m_last = '0;
   logic [15:0] m_rdata [2] = '{16'h0, 16'h0};
   logic        m_rerr  [2] = '{1'b0, 1'b0};
   bit          checking = 0;
   bit          log_pat = 0;
   string       gpat = "";
   int          n_rv1 = 0;

   always @(negedge clka) if (checking) begin
      logic        e_g0, e_g1, ge;
      logic [12:0] ga, e_addr;
      e_g1   = !rsta && req1 && (!req0 || deny >= 4);
      e_g0   = !rsta && req0 && !e_g1;
      ga     = e_g1 ? addr1 : addr0;
      ge     = int'(ga) >= DEPTH;
      e_addr = rsta ? 13'd0 : (e_g0 || e_g1) ? (ge ? 13'd0 : ga) : m_last;
      check("gnt0", gnt0, e_g0);
      check("gnt1", gnt1, e_g1);
      check("rom_addr", rom_addr, e_addr);

      if (p2.v) begin
         m_rdata[p2.port] = (int'(p2.addr) >= DEPTH) ? 16'h0 : rom_fn(p2.addr);
         m_rerr[p2.port]  = int'(p2.addr) >= DEPTH;
      end
      check("rvalid0", rvalid0, p2.v && !p2.port);
      check("rvalid1", rvalid1, p2.v &&  p2.port);
      check("rdata0", rdata0, m_rdata[0]);
      check("rerr0", rerr0, m_rerr[0]);
      check("rdata1", rdata1, m_rdata[1]);
      check("rerr1", rerr1, m_rerr[1]);

      if (log_pat && (gnt0 || gnt1)) gpat = {gpat, gnt1 ? "1" : "0"};
      if (rvalid1) n_rv1++;

      if (rsta) begin
         p1 = '0; p2 = '0; deny = 0; m_last = '0;
         m_rdata = '{16'h0, 16'h0};
         m_rerr  = '{1'b0, 1'b0};
      end else begin
         p2 = p1;
         p1 = '{v: e_g0 || e_g1, port: e_g1, addr: ga};
         if (e_g1 || !req1) deny = 0;
         else if (deny < 255) deny++;
         if (e_g0 || e_g1) m_last = ge ? 13'd0 : ga;
      end
   end

   initial begin
      @(posedge clka);
      checking = 1;
      step();
      @(negedge clka);
      check("rst_rvalid0", rvalid0, 0);
      check("rst_rdata1", rdata1, 0);
      check("rst_gnt0", gnt0, 0);
      step(); rsta = 1'b0;

      // Single port-0 read of address 5.
      step(); req0 = 1'b1; addr0 = 13'd5;
      @(negedge clka);
      check("t1_gnt0", gnt0, 1);
      check("t1_rom_addr", rom_addr, 13'd5);
      step(); req0 = 1'b0;
      step();
      @(negedge clka);
      check("t1_rvalid0", rvalid0, 1);
      check("t1_rdata0", rdata0, 16'hC6A5);
      check("t1_rerr0", rerr0, 0);
      check("t1_rvalid1", rvalid1, 0);

      // Continuous contention: every fifth grant goes to port 1.
      step(); req0 = 1'b1; req1 = 1'b1; addr0 = 13'd100; addr1 = 13'd8099; gpat = ""; log_pat = 1;
      repeat (9) step();
      step(); req0 = 1'b0; req1 = 1'b0; log_pat = 0;
      total++;
      if (gpat != "0000100001") begin
         bad++;
         $display("FAIL t2_pattern: got %s expected 0000100001", gpat);
      end
      repeat (3) step();

      // Port 1 sweeps every valid address back-to-back.
      n_rv1 = 0;
      for (int i = 0; i < DEPTH; i++) begin
         step(); req1 = 1'b1; addr1 = 13'(i);
      end
      step(); req1 = 1'b0;
      repeat (3) step();
      check("t3_count", n_rv1, 8100);
      check("t3_last_rdata1", rdata1, 16'h60BA);
      check("t3_last_rerr1", rerr1, 0);

      // Out-of-range addresses at both ends of the invalid range.
      step(); req1 = 1'b1; addr1 = 13'd8100;
      @(negedge clka);
      check("t4_rom_addr_8100", rom_addr, 0);
      step(); addr1 = 13'd8191;
      @(negedge clka);
      check("t4_rom_addr_8191", rom_addr, 0);
      step(); req1 = 1'b0;
      @(negedge clka);
      check("t4_rvalid1_a", rvalid1, 1);
      check("t4_rdata1_a", rdata1, 0);
      check("t4_rerr1_a", rerr1, 1);
      step();
      @(negedge clka);
      check("t4_rvalid1_b", rvalid1, 1);
      check("t4_rerr1_b", rerr1, 1);

      // Reset while a read is in flight.
      repeat (2) step();
      step(); req0 = 1'b1; addr0 = 13'd10;
      step(); addr0 = 13'd11; rsta = 1'b1;
      step(); addr0 = 13'd12; rsta = 1'b0;
      @(negedge clka);
      check("t5_rvalid0_n2", rvalid0, 0);
      check("t5_rdata0_rst", rdata0, 0);
      check("t5_gnt0_first", gnt0, 1);
      step(); req0 = 1'b0;
      @(negedge clka);
      check("t5_rvalid0_n3", rvalid0, 0);
      step();
      @(negedge clka);
      check("t5_rvalid0_n4", rvalid0, 1);
      check("t5_rdata0_n4", rdata0, 16'hCFA5);

      // Strict priority instance: port 1 never forced, counter saturation harmless.
      step(); z_req0 = 1'b1; z_req1 = 1'b1; z_addr0 = 13'd1; z_addr1 = 13'd2;
      for (int i = 0; i < 300; i++) begin
         @(negedge clka);
         check("t6_z_gnt1_low", z_gnt1, 0);
         check("t6_z_gnt0_high", z_gnt0, 1);
         step();
      end
      z_req0 = 1'b0;
      @(negedge clka);
      check("t6_z_gnt1_after_drop", z_gnt1, 1);
      check("t6_z_gnt0_after_drop", z_gnt0, 0);
      step(); z_req1 = 1'b0;
      repeat (3) step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
